// File: rtl/int_dispatch_queue.sv
// Integer dispatch queue: circular in-order FIFO between rename and the int issue queues.
// Up to INPORT_NUM uops enqueue per cycle. The oldest OUTPORT_NUM entries are presented
// combinationally, each lane with its own req/rdy handshake, and dispatch in order.
// Optional macro INTDQ_PERF_EN adds saturating full-stall and dispatch-blocked counters.
module int_dispatch_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned INPORT_NUM  = 4,
    parameter int unsigned OUTPORT_NUM = 4,
    parameter int unsigned DATA_WID    = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush,
    input  logic [INPORT_NUM-1:0]           i_enq_req,
    output logic                            o_can_enq,
    input  logic [INPORT_NUM*DATA_WID-1:0]  i_enq_data,
    output logic [OUTPORT_NUM-1:0]          o_disp_req,
    input  logic [OUTPORT_NUM-1:0]          i_disp_rdy,
    output logic [OUTPORT_NUM*DATA_WID-1:0] o_disp_data,
`ifdef INTDQ_PERF_EN
    output logic [31:0]                     o_perf_full_cycles,
    output logic [31:0]                     o_perf_disp_blocked,
`endif
    output logic [$clog2(DEPTH):0]          o_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Pointers carry one extra MSB as the wrap flag, so tail - head is the occupancy.
    logic [IDX_W:0]      r_head;
    logic [IDX_W:0]      r_tail;
    logic [DATA_WID-1:0] r_mem [DEPTH];

    logic [IDX_W:0]      w_count;
    logic [IDX_W:0]      w_free;
    logic [IDX_W:0]      w_enq_num;
    logic [IDX_W:0]      w_deq_num;
    logic                w_blocked;
    logic                w_enq_contig;
    logic [IDX_W-1:0]    w_wr_idx [INPORT_NUM];
    logic [IDX_W-1:0]    w_rd_idx [OUTPORT_NUM];

    assign w_count   = r_tail - r_head;
    assign w_free    = (IDX_W+1)'(DEPTH) - w_count;
    // Conservative: same-cycle dispatch is not credited toward free space.
    assign o_can_enq = !i_flush && (w_free >= (IDX_W+1)'(INPORT_NUM));
    assign o_count   = w_count;

    // Enqueue count, write indices and lane-contiguity check
    always_comb begin
        w_enq_num    = '0;
        w_enq_contig = 1'b1;
        for (int k = 0; k < INPORT_NUM; k++) begin
            w_enq_num   = w_enq_num + (IDX_W+1)'(i_enq_req[k]);
            w_wr_idx[k] = r_tail[IDX_W-1:0] + IDX_W'(k);
            if (k > 0 && i_enq_req[k] && !i_enq_req[k-1]) begin
                w_enq_contig = 1'b0;
            end
        end
    end

    // Dispatch lanes: zero-latency read; the first stalled lane blocks all younger lanes
    always_comb begin
        w_deq_num   = '0;
        w_blocked   = 1'b0;
        o_disp_req  = '0;
        o_disp_data = '0;
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            w_rd_idx[k]   = r_head[IDX_W-1:0] + IDX_W'(k);
            o_disp_req[k] = (w_count > (IDX_W+1)'(k)) && !i_flush;
            o_disp_data[k*DATA_WID +: DATA_WID] = r_mem[w_rd_idx[k]];
            if (!w_blocked && o_disp_req[k] && i_disp_rdy[k]) begin
                w_deq_num = w_deq_num + (IDX_W+1)'(1);
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

    // Pointer update; reset beats flush, flush beats enqueue/dispatch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + w_deq_num;
            if (o_can_enq) begin
                r_tail <= r_tail + w_enq_num;
            end
        end
    end

    // Payload storage, written only for accepted lanes
    always_ff @(posedge clk) begin
        if (!rst && o_can_enq) begin
            for (int k = 0; k < INPORT_NUM; k++) begin
                if (i_enq_req[k]) begin
                    r_mem[w_wr_idx[k]] <= i_enq_data[k*DATA_WID +: DATA_WID];
                end
            end
        end
    end

    a_enq_contig: assert property (@(posedge clk) disable iff (rst) w_enq_contig);

`ifdef INTDQ_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_blk;

    // Saturating perf counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full <= '0;
            r_perf_blk  <= '0;
        end else begin
            if (!o_can_enq && (|i_enq_req) && (r_perf_full != '1)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            if (o_disp_req[0] && !i_disp_rdy[0] && (r_perf_blk != '1)) begin
                r_perf_blk <= r_perf_blk + 32'd1;
            end
        end
    end

    assign o_perf_full_cycles  = r_perf_full;
    assign o_perf_disp_blocked = r_perf_blk;
`endif

endmodule

// File: tb/tb_int_dispatch_queue.sv
// Directed self-checking bench for int_dispatch_queue (default configuration).
module tb_int_dispatch_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flush;
    logic [3:0]    i_enq_req;
    logic          o_can_enq;
    logic [4*DW-1:0] i_enq_data;
    logic [3:0]    o_disp_req;
    logic [3:0]    i_disp_rdy;
    logic [4*DW-1:0] o_disp_data;
    logic [4:0]    o_count;
`ifdef INTDQ_PERF_EN
    logic [31:0]   o_perf_full_cycles;
    logic [31:0]   o_perf_disp_blocked;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int_dispatch_queue #(
        .DEPTH      (DEPTH),
        .INPORT_NUM (4),
        .OUTPORT_NUM(4),
        .DATA_WID   (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_flush            (i_flush),
        .i_enq_req          (i_enq_req),
        .o_can_enq          (o_can_enq),
        .i_enq_data         (i_enq_data),
        .o_disp_req         (o_disp_req),
        .i_disp_rdy         (i_disp_rdy),
        .o_disp_data        (o_disp_data),
`ifdef INTDQ_PERF_EN
        .o_perf_full_cycles (o_perf_full_cycles),
        .o_perf_disp_blocked(o_perf_disp_blocked),
`endif
        .o_count            (o_count)
    );

    always #5 clk = ~clk;

    // Lane k payload is base + k
    task automatic drive(input logic [3:0] req, input logic [63:0] base,
                         input logic [3:0] rdy, input logic fl);
        i_enq_req  = req;
        i_disp_rdy = rdy;
        i_flush    = fl;
        for (int k = 0; k < 4; k++) i_enq_data[k*DW +: DW] = base + 64'(k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        drive(4'hf, 64'h50, 4'h0, 1'b0);
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        rst = 1'b1;
        step();
        n_cmp++;
        if (o_count !== 5'd0) begin
            n_err++; $display("FAIL reset_count got %0d want 0", o_count);
        end
        n_cmp++;
        if (o_disp_req !== 4'b0000) begin
            n_err++; $display("FAIL reset_disp_req got %b want 0000", o_disp_req);
        end
        n_cmp++;
        if (o_can_enq !== 1'b1) begin
            n_err++; $display("FAIL reset_can_enq got %b want 1", o_can_enq);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_enq();
        drive(4'hf, 64'hA0, 4'h0, 1'b0);
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd4) begin
            n_err++; $display("FAIL basic_count got %0d want 4", o_count);
        end
        n_cmp++;
        if (o_disp_req !== 4'b1111) begin
            n_err++; $display("FAIL basic_disp_req got %b want 1111", o_disp_req);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (o_disp_data[k*DW +: DW] !== 64'hA0 + 64'(k)) begin
                n_err++;
                $display("FAIL basic_lane%0d got %h want %h", k, o_disp_data[k*DW +: DW],
                         64'hA0 + 64'(k));
            end
        end
        drive(4'h0, 64'h0, 4'hf, 1'b0);
        step();
        // empty queue: rdy must be ignored
        step();
        n_cmp++;
        if (o_count !== 5'd0 || o_disp_req !== 4'b0000) begin
            n_err++;
            $display("FAIL empty_state got count=%0d req=%b want 0/0000", o_count, o_disp_req);
        end
    endtask

    task automatic test_inorder_stall();
        for (int g = 0; g < 4; g++) begin
            drive(4'hf, 64'h100 + 64'(4 * g), 4'h0, 1'b0);
            step();
        end
        drive(4'h0, 64'h0, 4'b1101, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd16 || o_can_enq !== 1'b0) begin
            n_err++;
            $display("FAIL full16 got count=%0d can_enq=%b want 16/0", o_count, o_can_enq);
        end
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd15) begin
            n_err++; $display("FAIL stall_count got %0d want 15", o_count);
        end
        n_cmp++;
        if (o_disp_data[0 +: DW] !== 64'h101 || o_disp_data[DW +: DW] !== 64'h102) begin
            n_err++;
            $display("FAIL stall_head got %h,%h want 101,102", o_disp_data[0 +: DW],
                     o_disp_data[DW +: DW]);
        end
        drive(4'h0, 64'h0, 4'hf, 1'b0);
        for (int c = 0; c < 4; c++) step();
        n_cmp++;
        if (o_count !== 5'd0) begin
            n_err++; $display("FAIL stall_drain got %0d want 0", o_count);
        end
    endtask

    task automatic test_full_hold();
        for (int g = 0; g < 3; g++) begin
            drive(4'hf, 64'h200 + 64'(4 * g), 4'h0, 1'b0);
            step();
        end
        drive(4'b0001, 64'h20C, 4'h0, 1'b0);
        step();
        drive(4'hf, 64'h300, 4'b0011, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd13 || o_can_enq !== 1'b0) begin
            n_err++;
            $display("FAIL fill13 got count=%0d can_enq=%b want 13/0", o_count, o_can_enq);
        end
        step();
        drive(4'hf, 64'h300, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd11 || o_can_enq !== 1'b1) begin
            n_err++;
            $display("FAIL held_dispatch got count=%0d can_enq=%b want 11/1", o_count, o_can_enq);
        end
        n_cmp++;
        if (o_disp_data[0 +: DW] !== 64'h202) begin
            n_err++; $display("FAIL held_head got %h want 202", o_disp_data[0 +: DW]);
        end
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd15) begin
            n_err++; $display("FAIL held_accept got %0d want 15", o_count);
        end
        drive(4'h0, 64'h0, 4'hf, 1'b0);
        for (int c = 0; c < 4; c++) step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
    endtask

    task automatic test_wrap();
        drive(4'h0, 64'h0, 4'h0, 1'b1);
        step();
        for (int g = 0; g < 3; g++) begin
            drive(4'hf, 64'h400 + 64'(4 * g), 4'h0, 1'b0);
            step();
        end
        drive(4'b0011, 64'h40C, 4'h0, 1'b0);
        step();
        drive(4'h0, 64'h0, 4'hf, 1'b0);
        for (int c = 0; c < 4; c++) step();
        // head = tail = index 14 now
        drive(4'hf, 64'h500, 4'h0, 1'b0);
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd4) begin
            n_err++; $display("FAIL wrap_count got %0d want 4", o_count);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (o_disp_data[k*DW +: DW] !== 64'h500 + 64'(k)) begin
                n_err++;
                $display("FAIL wrap_lane%0d got %h want %h", k, o_disp_data[k*DW +: DW],
                         64'h500 + 64'(k));
            end
        end
        drive(4'h0, 64'h0, 4'hf, 1'b0);
        step();
        drive(4'hf, 64'h600, 4'h0, 1'b0);
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd4 || o_disp_data[0 +: DW] !== 64'h600
            || o_disp_data[3*DW +: DW] !== 64'h603) begin
            n_err++;
            $display("FAIL post_wrap got count=%0d lane0=%h lane3=%h want 4/600/603", o_count,
                     o_disp_data[0 +: DW], o_disp_data[3*DW +: DW]);
        end
    endtask

    task automatic test_flush();
        drive(4'h0, 64'h0, 4'h0, 1'b1);
        step();
        drive(4'hf, 64'h900, 4'h0, 1'b0);
        step();
        step();
        drive(4'b0001, 64'h908, 4'h0, 1'b0);
        step();
        drive(4'hf, 64'hA00, 4'hf, 1'b1);
        #1;
        n_cmp++;
        if (o_count !== 5'd9) begin
            n_err++; $display("FAIL flush_pre_count got %0d want 9", o_count);
        end
        n_cmp++;
        if (o_disp_req !== 4'b0000 || o_can_enq !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cycle got req=%b can_enq=%b want 0000/0", o_disp_req, o_can_enq);
        end
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd0 || o_disp_req !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_after got count=%0d req=%b want 0/0000", o_count, o_disp_req);
        end
        step();
        n_cmp++;
        if (o_count !== 5'd0) begin
            n_err++; $display("FAIL flush_discard got %0d want 0", o_count);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'hf, 64'h700, 4'h0, 1'b0);
        step();
        drive(4'b0001, 64'h704, 4'h0, 1'b0);
        step();
        drive(4'b0011, 64'h800, 4'b0111, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (o_disp_data[k*DW +: DW] !== 64'h700 + 64'(k)) begin
                n_err++;
                $display("FAIL b2b_pre_lane%0d got %h want %h", k, o_disp_data[k*DW +: DW],
                         64'h700 + 64'(k));
            end
        end
        step();
        drive(4'h0, 64'h0, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (o_count !== 5'd4) begin
            n_err++; $display("FAIL b2b_count got %0d want 4", o_count);
        end
        n_cmp++;
        if (o_disp_data[0 +: DW] !== 64'h703 || o_disp_data[DW +: DW] !== 64'h704
            || o_disp_data[2*DW +: DW] !== 64'h800 || o_disp_data[3*DW +: DW] !== 64'h801) begin
            n_err++;
            $display("FAIL b2b_order got %h,%h,%h,%h want 703,704,800,801",
                     o_disp_data[0 +: DW], o_disp_data[DW +: DW], o_disp_data[2*DW +: DW],
                     o_disp_data[3*DW +: DW]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_enq();
        test_inorder_stall();
        test_full_hold();
        test_wrap();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/int_dispatch_queue.md
Name: int_dispatch_queue

Overview:
- Circular in-order FIFO buffering renamed integer uops between rename/dispatch and the int exeBlock issue queues.
- Presents up to OUTPORT_NUM oldest entries per cycle on the dispatch port, using a per-lane req/rdy handshake toward the int block.
- Accepts up to INPORT_NUM uops per cycle from rename.
- Flushed on backend squash.

Parameters:
DEPTH, 16, entry count; power of two, ≥ 2*max(INPORT_NUM,OUTPORT_NUM)
INPORT_NUM, 4, enqueue lanes from rename
OUTPORT_NUM, 4, dispatch lanes (`INTDQ_DISP_WID)
DATA_WID, 64, bit width of one packed intDQEntry_t

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_flush  in  1  squash: drop all contents
i_enq_req  in  INPORT_NUM  per-lane enqueue valid; must be contiguous from lane 0
o_can_enq  out  1  queue can accept a full INPORT_NUM group this cycle
i_enq_data  in  INPORT_NUM*DATA_WID  enqueue payloads, lane 0 oldest
o_disp_req  out  OUTPORT_NUM  per-lane dispatch valid
i_disp_rdy  in  OUTPORT_NUM  per-lane accept from int block
o_disp_data  out  OUTPORT_NUM*DATA_WID  dispatch payloads, lane 0 = oldest
o_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage:
  - DEPTH x DATA_WID array.
  - Head/tail pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap flag.
  - count = tail - head (modulo arithmetic); empty when head==tail; full when indices are equal and wrap flags differ.
- Reset (rst=1 at posedge): head=tail=0, o_count=0, o_disp_req=0, o_can_enq=1. Array contents are don't-care.
- o_can_enq = (DEPTH - count) ≥ INPORT_NUM, combinational from registered count.
  - Does not account for same-cycle dispatch.
  - Forced 0 while i_flush=1.
- Enqueue:
  - enq_num = popcount(i_enq_req), accepted only when o_can_enq=1.
  - Lane k is written to array[(tail+k) mod DEPTH]; tail += enq_num at the posedge.
  - i_enq_req asserted while o_can_enq=0 is ignored; upstream holds it.
  - Non-contiguous i_enq_req is illegal; an SVA fires.
- Dispatch:
  - o_disp_req[k] = (count > k) && !i_flush.
  - o_disp_data[k] = array[(head+k) mod DEPTH], combinational read, zero latency.
  - Fires are in order: deq_num = number of leading lanes, from lane 0, with req&rdy. The first lane with req&!rdy blocks all younger lanes even if they are rdy.
  - The int block must ignore a lane's rdy beyond the first stall. Bench checks that such lanes are not consumed.
  - head += deq_num at the posedge.
- Simultaneous enq and deq in one cycle:
  - count_next = count + enq_num - deq_num.
  - An entry enqueued this cycle is never dispatched the same cycle (no bypass); it is first visible next cycle.
- Wrap-around:
  - Index arithmetic is modulo DEPTH and lanes may straddle index DEPTH-1→0.
  - The wrap flag toggles on pointer overflow.
- Flush:
  - i_flush=1 at a posedge sets head=tail=0 and count=0.
  - Flush overrides that cycle's enqueue and dispatch: no entry is consumed and o_disp_req=0 that cycle.
  - Flush also overrides rst-free operation; rst has priority over flush.
- Full: o_can_enq=0 whenever free < INPORT_NUM. Dispatch continues normally.
- Empty: o_disp_req=0. i_disp_rdy is ignored.
- o_count is a registered value, updated at every posedge.

Optional Feature:
INTDQ_PERF_EN:
- When defined, adds output o_perf_full_cycles (32-bit) and o_perf_disp_blocked (32-bit).
  - o_perf_full_cycles counts cycles with o_can_enq=0 && |i_enq_req.
  - o_perf_disp_blocked counts cycles with o_disp_req[0]=1 && !i_disp_rdy[0].
  - Both are cleared by rst, not by i_flush, and saturate at all-ones.
- Without the macro, the ports and counters are absent and there is no logic overhead.

Test Plan:
- Reset, then enq 4 uops (A..D) in one cycle with i_disp_rdy=0 → next cycle o_count=4, o_disp_req=4'b1111, o_disp_data lanes=A,B,C,D.
- 16 entries are queued. Apply i_disp_rdy=4'b1101 → only lane 0 fires; o_count 16→15, and the new head shows B on lane 0.
- Fill to 13 → o_can_enq=0. Enq req is held; dispatch of 2 → o_count=11 and o_can_enq=1 next cycle; the held group is accepted the following cycle (o_count=15).
- Drive head/tail to index 14, enq 4 and dispatch 4 over a wrap → data order is preserved across 15→0 and the wrap flag toggles.
- o_count=9 with i_flush=1 plus enq 4 and rdy=4'b1111 in the same cycle → next cycle o_count=0, o_disp_req=0; the flushed-cycle enqueue is discarded.
- Same-cycle enq 2 / deq 3 with count=5 → o_count=4, and newly enqueued entries are not dispatched that cycle.
